// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if: upstream/downstream handshake and data bundle for imm_extend_pipe
interface imm_extend_pipe_if #(parameter int IN_NBITS = 16, parameter int OUT_NBITS = 32);
  logic                 i_flush;
  logic                 i_valid;
  logic                 o_ready;
  logic [IN_NBITS-1:0]  i_signal;
  logic [1:0]           i_extension_mode;
  logic                 o_valid;
  logic                 i_ready;
  logic [OUT_NBITS-1:0] o_ext_signal;
  modport master (output i_flush, i_valid, i_signal, i_extension_mode, i_ready,
                  input  o_ready, o_valid, o_ext_signal);
  modport slave  (input  i_flush, i_valid, i_signal, i_extension_mode, i_ready,
                  output o_ready, o_valid, o_ext_signal);
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate extender with 2-entry skid buffer and flush
module imm_extend_pipe #(
  parameter int IN_NBITS  = 16,
  parameter int OUT_NBITS = 32,
  parameter int BR_SHIFT  = 2
) (
  input logic i_clk,
  input logic i_reset,
  imm_extend_pipe_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, next;
  logic [OUT_NBITS-1:0] zx, sx, ext, main, skid;
  logic accept, pop, ld_main, ld_skid, from_skid;
  always_comb begin
    zx  = OUT_NBITS'(bus.i_signal);
    sx  = OUT_NBITS'($signed(bus.i_signal));
    ext = bus.i_extension_mode == 2'b00 ? zx :
          bus.i_extension_mode == 2'b01 ? sx :
          bus.i_extension_mode == 2'b10 ? zx << (OUT_NBITS - IN_NBITS) :
                                          sx << BR_SHIFT;
  end
  assign bus.o_valid      = state != EMPTY;
  assign bus.o_ready      = state != FULL;
  assign bus.o_ext_signal = main;
  assign accept = bus.i_valid && bus.o_ready;
  assign pop    = bus.o_valid && bus.i_ready;
  // flush wins over both accept and pop, so nothing loads on a flush cycle
  always_comb begin
    next      = state;
    ld_main   = 1'b0;
    ld_skid   = 1'b0;
    from_skid = 1'b0;
    if (bus.i_flush) next = EMPTY;
    else
      case (state)
        EMPTY: if (accept) begin
          next    = ONE;
          ld_main = 1'b1;
        end
        ONE: if (accept && pop) ld_main = 1'b1;
        else if (accept) begin
          next    = FULL;
          ld_skid = 1'b1;
        end
        else if (pop) next = EMPTY;
        FULL: if (pop) begin
          next      = ONE;
          from_skid = 1'b1;
        end
        default: next = EMPTY;
      endcase
  end
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      state <= EMPTY;
      main  <= '0;
      skid  <= '0;
    end else begin
      state <= next;
      if (ld_main || from_skid) main <= from_skid ? skid : ext;
      if (ld_skid) skid <= ext;
    end
endmodule
